p_encoder_rr: RTL and testbench

Parametrised N-input priority encoder with registered output, selectable fixed-priority or round-robin arbitration, and a valid/ready output handshake. It replaces the combinational 8:3 priority encoder wherever a request vector must be converted to a one-hot grant plus binary index under back-pressure. Typical uses are interrupt-source selection and shared-resource arbitration.

---
 rtl/p_encoder_rr.sv | 74 +++++++
 tb/tb_p_encoder_rr.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/p_encoder_rr.sv
// p_encoder_rr: N-input priority encoder, registered one-hot/index output.
// Fixed or round-robin arbitration behind a valid/ready output slot.
module p_encoder_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant
);

  logic [W-1:0] ptr;
  logic [N-1:0] lo_mask;
  logic [N-1:0] lo_req;
  logic [W-1:0] win;
  logic         free;

  function automatic logic [W-1:0] top_bit(
    input logic [N-1:0] v
  );
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) r = W'(i);
    return r;
  endfunction

  assign free = !out_valid || out_ready;

  // Mask of positions at or below ptr (first half of the RR search)
  always_comb begin
    lo_mask = '0;
    for (int i = 0; i < N; i++)
      lo_mask[i] = (W'(i) <= ptr);
  end

  // Winner: RR prefers highest bit <= ptr, else wraps to highest overall
  always_comb begin
    lo_req = req & lo_mask;
    if (mode && |lo_req)
      win = top_bit(lo_req);
    else
      win = top_bit(req);
  end

  // Output slot and RR pointer; loads only when the slot is free
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      idx       <= '0;
      grant     <= '0;
      ptr       <= W'(N-1);
    end else if (free) begin
      if (|req) begin
        out_valid <= 1'b1;
        idx       <= win;
        grant     <= N'(1) << win;
        if (mode)
          ptr <= (win == '0) ? W'(N-1)
                             : win - W'(1);
      end else begin
        out_valid <= 1'b0;
        idx       <= '0;
        grant     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_p_encoder_rr.sv
// tb_p_encoder_rr: scoreboard bench for p_encoder_rr.
// Drives N=8 and N=5 instances; expectations queued before each edge.
module tb_p_encoder_rr;

  localparam int N  = 8;
  localparam int W  = 3;
  localparam int N5 = 5;
  localparam int W5 = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic          mode;
  logic          out_ready;
  logic          out_valid;
  logic [W-1:0]  idx;
  logic [N-1:0]  grant;

  logic [N5-1:0] req5;
  logic          mode5;
  logic          ready5;
  logic          valid5;
  logic [W5-1:0] idx5;
  logic [N5-1:0] grant5;

  typedef struct packed {
    logic         v;
    logic [W-1:0] i;
    logic [N-1:0] g;
  } slot_t;

  slot_t exp_q[$];
  int    exp5_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  logic         m_v;
  logic [W-1:0] m_i;
  logic [W-1:0] m_p;
  logic [N-1:0] m_g;

  always #5 clk = ~clk;

  p_encoder_rr #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mode      (mode),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .idx       (idx),
    .grant     (grant)
  );

  p_encoder_rr #(.N(N5)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .req       (req5),
    .mode      (mode5),
    .out_ready (ready5),
    .out_valid (valid5),
    .idx       (idx5),
    .grant     (grant5)
  );

  task automatic check_eq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Reference: modular descending search from ptr
  task automatic model_edge();
    int c;
    if (rst) begin
      m_v = 1'b0; m_i = '0; m_g = '0;
      m_p = W'(N-1);
    end else if (m_v && !out_ready) begin
    end else if (req == '0) begin
      m_v = 1'b0; m_i = '0; m_g = '0;
    end else begin
      c = -1;
      for (int k = 0; k < N; k++) begin
        int t;
        t = mode ? (int'(m_p) - k + N) % N
                 : N - 1 - k;
        if (c < 0 && req[t]) c = t;
      end
      m_v = 1'b1;
      m_i = W'(c);
      m_g = N'(1) << c;
      if (mode)
        m_p = (c == 0) ? W'(N-1) : W'(c - 1);
    end
    exp_q.push_back(slot_t'{m_v, m_i, m_g});
  endtask

  task automatic step();
    slot_t e;
    int    x;
    model_edge();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("sb_valid", 32'(out_valid), 32'(e.v));
    check_eq("sb_idx", 32'(idx), 32'(e.i));
    check_eq("sb_grant", 32'(grant), 32'(e.g));
    if (exp5_q.size() > 0) begin
      x = exp5_q.pop_front();
      check_eq("n5_valid", 32'(valid5), 32'(1));
      check_eq("n5_idx", 32'(idx5), 32'(x));
      check_eq("n5_grant", 32'(grant5),
               32'(1) << x);
    end
  endtask

  int rr_seq[9]  = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
  int sp_rdy[7]  = '{1, 0, 0, 1, 1, 0, 1};
  int sp_idx[7]  = '{7, 7, 7, 0, 7, 7, 0};
  int n5_seq[6]  = '{4, 3, 2, 1, 0, 4};

  initial begin
    rst       = 1'b1;
    req       = 8'hFF;
    mode      = 1'b1;
    out_ready = 1'b1;
    req5      = '0;
    mode5     = 1'b1;
    ready5    = 1'b1;

    // reset with requests pending
    step();
    step();
    check_eq("rst_valid", 32'(out_valid), 32'(0));
    check_eq("rst_idx", 32'(idx), 32'(0));
    check_eq("rst_grant", 32'(grant), 32'(0));
    rst = 1'b0;
    step();
    check_eq("rst_first_rr", 32'(idx), 32'(7));

    // fixed priority
    mode = 1'b0;
    req  = 8'b0010_0110;
    step();
    check_eq("fix_idx", 32'(idx), 32'(5));
    check_eq("fix_grant", 32'(grant), 32'h20);
    check_eq("fix_valid", 32'(out_valid), 32'(1));
    req = 8'h00;
    step();
    check_eq("empty_valid", 32'(out_valid), 32'(0));
    check_eq("empty_idx", 32'(idx), 32'(0));

    // stall holds the grant
    req = 8'b0010_0110;
    step();
    out_ready = 1'b0;
    req       = 8'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_idx", 32'(idx), 32'(5));
      check_eq("stall_grant", 32'(grant), 32'h20);
    end
    out_ready = 1'b1;
    step();
    check_eq("unstall_idx", 32'(idx), 32'(0));
    check_eq("unstall_grant", 32'(grant), 32'h01);

    // round-robin full request
    rst = 1'b1;
    step();
    rst  = 1'b0;
    mode = 1'b1;
    req  = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step();
      check_eq("rr_idx", 32'(idx), 32'(rr_seq[i]));
    end

    // round-robin sparse with pauses
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 8'b1000_0001;
    for (int i = 0; i < 7; i++) begin
      out_ready = sp_rdy[i][0];
      step();
      check_eq("sparse_idx", 32'(idx), 32'(sp_idx[i]));
    end

    // reset while a grant is stalled, ptr at 3
    out_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 8'hFF;
    for (int i = 0; i < 4; i++) step();
    check_eq("mid_idx4", 32'(idx), 32'(4));
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    check_eq("mid_rst_valid", 32'(out_valid), 32'(0));
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    check_eq("mid_rst_idx", 32'(idx), 32'(7));

    // random traffic against the model
    for (int i = 0; i < 80; i++) begin
      req       = N'($urandom);
      if (($urandom_range(0, 3)) == 0) req = '0;
      mode      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 39) == 0);
      step();
      check_eq("onehot", 32'($countones(grant)),
               32'(out_valid));
    end

    // N=5 wrap
    rst = 1'b1;
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    req5      = 5'h1F;
    for (int i = 0; i < 6; i++) begin
      exp5_q.push_back(n5_seq[i]);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
